ld_en_ud_bcd_cnt: RTL and testbench

//   Parametrised multi-digit up/down counter with load and enable. Each digit

---
 rtl/ld_en_ud_bcd_cnt.sv | 115 +++++++++++
 tb/tb_ld_en_ud_bcd_cnt.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ld_en_ud_bcd_cnt.sv
// Multi-digit up/down counter, each digit modulo MODULUS, with load, enable, terminal count and wrap pulse.
// Optional saturation mode (input sat_i) is built when LD_EN_UD_BCD_CNT_SAT_EN is defined.
module ld_en_ud_bcd_cnt #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic                en_i,
  input  logic                up_i,
`ifdef LD_EN_UD_BCD_CNT_SAT_EN
  input  logic                sat_i,
`endif
  input  logic [4*DIGITS-1:0] in_i,
  output logic [4*DIGITS-1:0] q_o,
  output logic                tc_o,
  output logic                wrap_o,
  output logic                load_err_o
);

  localparam int         W        = 4 * DIGITS;
  localparam logic [3:0] MaxDigit = 4'(MODULUS - 1);
  localparam logic [4:0] ModVal   = 5'(MODULUS);

  logic [W-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic         loadErr_q, loadErr_d;

  logic [W-1:0] loadVal;
  logic         loadIllegal;
  logic [W-1:0] countVal;
  logic         chain;
  logic         allMax, allZero;
  logic         atBound;
  logic         satHold;

  // Illegal load digits are clamped to the largest legal digit and flagged.
  always_comb begin
    loadVal     = '0;
    loadIllegal = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ({1'b0, in_i[4*i +: 4]} < ModVal) begin
        loadVal[4*i +: 4] = in_i[4*i +: 4];
      end else begin
        loadVal[4*i +: 4] = MaxDigit;
        loadIllegal       = 1'b1;
      end
    end
  end

  always_comb begin
    allMax  = 1'b1;
    allZero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (q_q[4*i +: 4] != MaxDigit) allMax  = 1'b0;
      if (q_q[4*i +: 4] != 4'd0)     allZero = 1'b0;
    end
  end

  // Ripple carry/borrow: a digit steps only while every lower digit sits at its rollover value.
  always_comb begin
    countVal = q_q;
    chain    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (chain) begin
        if (up_i) begin
          countVal[4*i +: 4] = (q_q[4*i +: 4] == MaxDigit) ? 4'd0 : q_q[4*i +: 4] + 4'd1;
        end else begin
          countVal[4*i +: 4] = (q_q[4*i +: 4] == 4'd0) ? MaxDigit : q_q[4*i +: 4] - 4'd1;
        end
      end
      chain = chain & (up_i ? (q_q[4*i +: 4] == MaxDigit) : (q_q[4*i +: 4] == 4'd0));
    end
  end

  assign atBound = up_i ? allMax : allZero;
  assign tc_o    = en_i & atBound;

`ifdef LD_EN_UD_BCD_CNT_SAT_EN
  assign satHold = sat_i & atBound;
`else
  assign satHold = 1'b0;
`endif

  always_comb begin
    q_d       = q_q;
    wrap_d    = 1'b0;
    loadErr_d = loadErr_q;
    if (load_i) begin
      q_d       = loadVal;
      loadErr_d = loadIllegal;
    end else if (en_i && !satHold) begin
      q_d    = countVal;
      wrap_d = atBound;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q       <= '0;
      wrap_q    <= 1'b0;
      loadErr_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      wrap_q    <= wrap_d;
      loadErr_q <= loadErr_d;
    end
  end

  assign q_o        = q_q;
  assign wrap_o     = wrap_q;
  assign load_err_o = loadErr_q;

endmodule

// File: tb/tb_ld_en_ud_bcd_cnt.sv
// Scoreboard bench for ld_en_ud_bcd_cnt: a 2-digit decimal instance and a 3-digit modulo-6 instance.
module tb_ld_en_ud_bcd_cnt;

  logic clk = 1'b0;
  logic rstN;

  logic        loadA, enA, upA, satA;
  logic [7:0]  inA, qA;
  logic        tcA, wrapA, errA;

  logic        loadB, enB, upB, satB;
  logic [11:0] inB, qB;
  logic        tcB, wrapB, errB;

  typedef struct {
    logic [11:0] q;
    logic        wrap;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  ld_en_ud_bcd_cnt #(.DIGITS(2), .MODULUS(10)) dutA (
    .clk_i(clk), .rst_ni(rstN), .load_i(loadA), .en_i(enA), .up_i(upA),
`ifdef LD_EN_UD_BCD_CNT_SAT_EN
    .sat_i(satA),
`endif
    .in_i(inA), .q_o(qA), .tc_o(tcA), .wrap_o(wrapA), .load_err_o(errA)
  );

  ld_en_ud_bcd_cnt #(.DIGITS(3), .MODULUS(6)) dutB (
    .clk_i(clk), .rst_ni(rstN), .load_i(loadB), .en_i(enB), .up_i(upB),
`ifdef LD_EN_UD_BCD_CNT_SAT_EN
    .sat_i(satB),
`endif
    .in_i(inB), .q_o(qB), .tc_o(tcB), .wrap_o(wrapB), .load_err_o(errB)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drvA(input logic l, input logic en, input logic up, input logic sat,
                      input logic [7:0] din, input logic [7:0] expQ, input logic expW, input logic expE);
    loadA = l; enA = en; upA = up; satA = sat; inA = din;
    sb.push_back('{q: {4'h0, expQ}, wrap: expW, err: expE});
  endtask

  task automatic drvB(input logic l, input logic en, input logic up,
                      input logic [11:0] din, input logic [11:0] expQ, input logic expW, input logic expE);
    loadB = l; enB = en; upB = up; satB = 1'b0; inB = din;
    sb.push_back('{q: expQ, wrap: expW, err: expE});
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (qA !== 8'h00 || wrapA !== 1'b0 || errA !== 1'b0)
      $display("[TB] FAIL reset_initial: q=%h wrap=%b err=%b, want q=00 wrap=0 err=0", qA, wrapA, errA);
    else passes++;
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       drvA(1, 0, 1, 0, 8'h5F, 8'h59, 0, 1);
        1:       drvA(0, 1, 0, 0, 8'h00, 8'h58, 0, 1);
        default: drvA(0, 1, 0, 0, 8'h00, 8'h57, 0, 1);
      endcase
      step();
      e = sb.pop_front();
      checks++;
      if ({4'h0, qA} !== e.q || wrapA !== e.wrap || errA !== e.err)
        $display("[TB] FAIL reset_setup[%0d]: q=%h wrap=%b err=%b, want q=%h wrap=%b err=%b",
                 k, qA, wrapA, errA, e.q[7:0], e.wrap, e.err);
      else passes++;
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (qA !== 8'h00 || wrapA !== 1'b0 || errA !== 1'b0)
      $display("[TB] FAIL reset_async: q=%h wrap=%b err=%b, want q=00 wrap=0 err=0", qA, wrapA, errA);
    else passes++;
    drvA(0, 1, 1, 0, 8'h00, 8'h01, 0, 0);
    #1 rstN = 1'b1;
    step();
    e = sb.pop_front();
    checks++;
    if ({4'h0, qA} !== e.q || wrapA !== e.wrap || errA !== e.err)
      $display("[TB] FAIL reset_resume: q=%h wrap=%b err=%b, want q=%h wrap=%b err=%b",
               qA, wrapA, errA, e.q[7:0], e.wrap, e.err);
    else passes++;
  endtask

  task automatic test_load_count();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       drvA(1, 0, 1, 0, 8'h19, 8'h19, 0, 0);
        1:       drvA(0, 1, 1, 0, 8'h00, 8'h20, 0, 0);
        default: drvA(0, 1, 1, 0, 8'h00, 8'h21, 0, 0);
      endcase
      step();
      e = sb.pop_front();
      checks++;
      if ({4'h0, qA} !== e.q || wrapA !== e.wrap || errA !== e.err)
        $display("[TB] FAIL load_count[%0d]: q=%h wrap=%b err=%b, want q=%h wrap=%b err=%b",
                 k, qA, wrapA, errA, e.q[7:0], e.wrap, e.err);
      else passes++;
    end
  endtask

  task automatic test_up_wrap();
    logic expTc;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin drvA(1, 0, 1, 0, 8'h99, 8'h99, 0, 0); expTc = 1'b0; end
        1:       begin drvA(0, 1, 1, 0, 8'h00, 8'h00, 1, 0); expTc = 1'b1; end
        default: begin drvA(0, 0, 1, 0, 8'h00, 8'h00, 0, 0); expTc = 1'b0; end
      endcase
      #1;
      checks++;
      if (tcA !== expTc) $display("[TB] FAIL up_wrap_tc[%0d]: tc=%b, want %b", k, tcA, expTc);
      else passes++;
      step();
      e = sb.pop_front();
      checks++;
      if ({4'h0, qA} !== e.q || wrapA !== e.wrap || errA !== e.err)
        $display("[TB] FAIL up_wrap[%0d]: q=%h wrap=%b err=%b, want q=%h wrap=%b err=%b",
                 k, qA, wrapA, errA, e.q[7:0], e.wrap, e.err);
      else passes++;
    end
  endtask

  task automatic test_down_wrap();
    logic expTc;
    for (int k = 0; k < 2; k++) begin
      case (k)
        0:       begin drvA(0, 1, 0, 0, 8'h00, 8'h99, 1, 0); expTc = 1'b1; end
        default: begin drvA(0, 1, 0, 0, 8'h00, 8'h98, 0, 0); expTc = 1'b0; end
      endcase
      #1;
      checks++;
      if (tcA !== expTc) $display("[TB] FAIL down_wrap_tc[%0d]: tc=%b, want %b", k, tcA, expTc);
      else passes++;
      step();
      e = sb.pop_front();
      checks++;
      if ({4'h0, qA} !== e.q || wrapA !== e.wrap || errA !== e.err)
        $display("[TB] FAIL down_wrap[%0d]: q=%h wrap=%b err=%b, want q=%h wrap=%b err=%b",
                 k, qA, wrapA, errA, e.q[7:0], e.wrap, e.err);
      else passes++;
    end
  endtask

  task automatic test_load_err();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       drvA(1, 1, 1, 0, 8'h3C, 8'h39, 0, 1);
        1:       drvA(0, 0, 1, 0, 8'h00, 8'h39, 0, 1);
        default: drvA(1, 0, 1, 0, 8'h12, 8'h12, 0, 0);
      endcase
      step();
      e = sb.pop_front();
      checks++;
      if ({4'h0, qA} !== e.q || wrapA !== e.wrap || errA !== e.err)
        $display("[TB] FAIL load_err[%0d]: q=%h wrap=%b err=%b, want q=%h wrap=%b err=%b",
                 k, qA, wrapA, errA, e.q[7:0], e.wrap, e.err);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      case (k)
        0:       drvA(0, 1, 1, 0, 8'h00, 8'h13, 0, 0);
        1:       drvA(0, 1, 0, 0, 8'h00, 8'h12, 0, 0);
        2:       drvA(0, 1, 0, 0, 8'h00, 8'h11, 0, 0);
        3:       drvA(0, 1, 1, 0, 8'h00, 8'h12, 0, 0);
        4:       drvA(0, 0, 0, 0, 8'h00, 8'h12, 0, 0);
        5:       drvA(1, 0, 0, 0, 8'h29, 8'h29, 0, 0);
        6:       drvA(0, 1, 1, 0, 8'h00, 8'h30, 0, 0);
        default: drvA(0, 1, 0, 0, 8'h00, 8'h29, 0, 0);
      endcase
      step();
      e = sb.pop_front();
      checks++;
      if ({4'h0, qA} !== e.q || wrapA !== e.wrap || errA !== e.err)
        $display("[TB] FAIL back_to_back[%0d]: q=%h wrap=%b err=%b, want q=%h wrap=%b err=%b",
                 k, qA, wrapA, errA, e.q[7:0], e.wrap, e.err);
      else passes++;
    end
  endtask

`ifdef LD_EN_UD_BCD_CNT_SAT_EN
  task automatic test_saturate();
    logic expTc;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0:       begin drvA(1, 0, 1, 1, 8'h99, 8'h99, 0, 0); expTc = 1'b0; end
        1, 2, 3: begin drvA(0, 1, 1, 1, 8'h00, 8'h99, 0, 0); expTc = 1'b1; end
        4:       begin drvA(0, 1, 1, 0, 8'h00, 8'h00, 1, 0); expTc = 1'b1; end
        5:       begin drvA(0, 1, 0, 1, 8'h00, 8'h00, 0, 0); expTc = 1'b1; end
        default: begin drvA(0, 1, 0, 0, 8'h00, 8'h99, 1, 0); expTc = 1'b1; end
      endcase
      #1;
      checks++;
      if (tcA !== expTc) $display("[TB] FAIL saturate_tc[%0d]: tc=%b, want %b", k, tcA, expTc);
      else passes++;
      step();
      e = sb.pop_front();
      checks++;
      if ({4'h0, qA} !== e.q || wrapA !== e.wrap || errA !== e.err)
        $display("[TB] FAIL saturate[%0d]: q=%h wrap=%b err=%b, want q=%h wrap=%b err=%b",
                 k, qA, wrapA, errA, e.q[7:0], e.wrap, e.err);
      else passes++;
    end
    satA = 1'b0;
  endtask
`endif

  task automatic test_mod6();
    logic expTc;
    loadA = 1'b0; enA = 1'b0;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0:       begin drvB(1, 0, 1, 12'h789, 12'h555, 0, 1); expTc = 1'b0; end
        1:       begin drvB(0, 1, 1, 12'h000, 12'h000, 1, 1); expTc = 1'b1; end
        2:       begin drvB(1, 0, 1, 12'h554, 12'h554, 0, 0); expTc = 1'b0; end
        3:       begin drvB(0, 1, 1, 12'h000, 12'h555, 0, 0); expTc = 1'b0; end
        default: begin drvB(0, 1, 0, 12'h000, 12'h554, 0, 0); expTc = 1'b0; end
      endcase
      #1;
      checks++;
      if (tcB !== expTc) $display("[TB] FAIL mod6_tc[%0d]: tc=%b, want %b", k, tcB, expTc);
      else passes++;
      step();
      e = sb.pop_front();
      checks++;
      if (qB !== e.q || wrapB !== e.wrap || errB !== e.err)
        $display("[TB] FAIL mod6[%0d]: q=%h wrap=%b err=%b, want q=%h wrap=%b err=%b",
                 k, qB, wrapB, errB, e.q, e.wrap, e.err);
      else passes++;
    end
  endtask

  initial begin
    rstN  = 1'b0;
    loadA = 1'b0; enA = 1'b0; upA = 1'b1; satA = 1'b0; inA = '0;
    loadB = 1'b0; enB = 1'b0; upB = 1'b1; satB = 1'b0; inB = '0;
    $display("[TB] starting");
    test_reset();
    test_load_count();
    test_up_wrap();
    test_down_wrap();
    test_load_err();
    test_back_to_back();
`ifdef LD_EN_UD_BCD_CNT_SAT_EN
    test_saturate();
`endif
    test_mod6();
    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
